// File: rtl/rstcon_seq_multi.sv
// rstcon_seq_multi
//
// N-channel reset sequencer for the SoC reset controller. It sits upstream
// of the per-domain reset synchronisers.
//
// Assertion is asynchronous: while rst is high, every channel reset is high.
// Release is synchronous and happens in ascending channel order:
//   - All channels are held for HOLD_CYCLES after the reset source clears.
//   - Each following channel is released STEP_CYCLES edges after the one
//     before it.
//
// A synchronous full_rst_req re-runs the whole sequence. Once the sequence
// has finished, each channel can be pulsed again through its own
// software reset request. With CASCADE=1, a request on channel i also pulses
// every channel above it.
//
// Ports
//   clk           sole clock
//   rst           asynchronous active-high reset
//   full_rst_req  synchronous request to re-run the whole sequence (level)
//   sw_rst_req    per-channel synchronous software reset request (level)
//   rst_out       active-high channel resets, bit 0 released first (registered)
//   seq_done      high once the sequencer has released every channel (registered)
//   stage         number of channels released so far by the sequencer (registered)
//
// The FSM state is held in state_q (type state_t) so that checkers can be
// bound to it.
module rstcon_seq_multi #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int MIN_HOLD    = 4,
    parameter int CASCADE     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          full_rst_req,
    input  logic [CHANNELS-1:0]           sw_rst_req,
    output logic [CHANNELS-1:0]           rst_out,
    output logic                          seq_done,
    output logic [$clog2(CHANNELS+1)-1:0] stage
);

    localparam int STAGE_W = $clog2(CHANNELS + 1);
    localparam int MAX_A   = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int MAX_CNT = (MAX_A > MIN_HOLD) ? MAX_A : MIN_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_SAT    = '1;
    localparam logic [CNT_W-1:0]   HOLD_END   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   STEP_END   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SW_END     = CNT_W'(MIN_HOLD - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        STEP = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic                 seq_done_q, seq_done_d;
    logic [CHANNELS-1:0]  rst_out_q, rst_out_d;
    logic [CHANNELS-1:0]  sw_act_q, sw_act_d;
    logic [CNT_W-1:0]     sw_cnt_q [CHANNELS];
    logic [CNT_W-1:0]     sw_cnt_d [CHANNELS];
    logic [CHANNELS-1:0]  eff_req;
    logic [1:0]           sync_q;
    logic                 rst_sync_q;

    // Deassertion synchroniser.
    //   - sync_q[0] clears at the first edge after rst falls.
    //   - rst_sync (sync_q[1]) clears at the second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_sync_q = sync_q[1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    // Effective software request per channel.
    // With cascade enabled, a request on any lower channel also counts.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        eff_req = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            eff_req[j] = sw_rst_req[j] | ((CASCADE != 0) && seen);
            seen       = seen | sw_rst_req[j];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        seq_done_d = seq_done_q;
        sw_act_d   = sw_act_q;
        sw_cnt_d   = sw_cnt_q;
        rst_out_d  = '1;

        if (full_rst_req) begin
            // Keep the sequence parked at the start of HOLD while the request
            // stays high. Any software pulse in flight is discarded.
            state_d    = HOLD;
            cnt_d      = '0;
            stage_d    = '0;
            seq_done_d = 1'b0;
            sw_act_d   = '0;
            for (int j = 0; j < CHANNELS; j++) begin
                sw_cnt_d[j] = '0;
            end
        end else begin
            case (state_q)
                SYNC: begin
                    // rst_sync clears at this very edge, so this edge is
                    // already the first hold edge.
                    if (!sync_q[0]) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!rst_sync_q && (cnt_q >= HOLD_END)) begin
                        stage_d = STAGE_W'(1);
                        cnt_d   = '0;
                        if (CHANNELS == 1) begin
                            state_d    = RUN;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = STEP;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                STEP: begin
                    if (cnt_q >= STEP_END) begin
                        stage_d = stage_q + 1'b1;
                        cnt_d   = '0;
                        if (stage_q == LAST_STAGE) begin
                            state_d    = RUN;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                RUN: begin
                    // The release happens at the MIN_HOLD-th edge after the
                    // last edge that sampled the request high.
                    for (int j = 0; j < CHANNELS; j++) begin
                        if (eff_req[j]) begin
                            sw_act_d[j] = 1'b1;
                            sw_cnt_d[j] = '0;
                        end else if (sw_act_q[j]) begin
                            if (sw_cnt_q[j] >= SW_END) begin
                                sw_act_d[j] = 1'b0;
                                sw_cnt_d[j] = '0;
                            end else begin
                                sw_cnt_d[j] = sat_inc(sw_cnt_q[j]);
                            end
                        end
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end

        // Channel k is released by the sequencer once stage exceeds k.
        // A software pulse can re-assert it on top of that.
        for (int k = 0; k < CHANNELS; k++) begin
            rst_out_d[k] = (STAGE_W'(k) >= stage_d) | sw_act_d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            stage_q    <= '0;
            seq_done_q <= 1'b0;
            rst_out_q  <= '1;
            sw_act_q   <= '0;
            for (int j = 0; j < CHANNELS; j++) begin
                sw_cnt_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            seq_done_q <= seq_done_d;
            rst_out_q  <= rst_out_d;
            sw_act_q   <= sw_act_d;
            for (int j = 0; j < CHANNELS; j++) begin
                sw_cnt_q[j] <= sw_cnt_d[j];
            end
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;
    assign stage    = stage_q;

endmodule
